// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - EX operand, pipeline-stage and hazard signals of the forwarding unit
interface fwd_hazard_unit_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5
);
  logic                      pipe_stall;
  logic                      ex_valid;
  logic [NUM_SRC*REG_AW-1:0] ex_rs_addr;
  logic [NUM_SRC-1:0]        ex_rs_used;
  logic [NUM_SRC*XLEN-1:0]   ex_rs_data;
  logic                      mem_valid;
  logic                      mem_regwrite;
  logic                      mem_is_load;
  logic [REG_AW-1:0]         mem_rd;
  logic [XLEN-1:0]           mem_data;
  logic                      wb_valid;
  logic                      wb_regwrite;
  logic [REG_AW-1:0]         wb_rd;
  logic [XLEN-1:0]           wb_data;
  logic [NUM_SRC*XLEN-1:0]   ex_op_data;
  logic [NUM_SRC*2-1:0]      fwd_src;
  logic                      load_use;
  logic                      mem_bubble;
  logic [31:0]               stall_cycles;
  logic [31:0]               lu_events;

  modport master (
    output pipe_stall, ex_valid, ex_rs_addr, ex_rs_used, ex_rs_data,
           mem_valid, mem_regwrite, mem_is_load, mem_rd, mem_data,
           wb_valid, wb_regwrite, wb_rd, wb_data,
    input  ex_op_data, fwd_src, load_use, mem_bubble, stall_cycles, lu_events
  );

  modport slave (
    input  pipe_stall, ex_valid, ex_rs_addr, ex_rs_used, ex_rs_data,
           mem_valid, mem_regwrite, mem_is_load, mem_rd, mem_data,
           wb_valid, wb_regwrite, wb_rd, wb_data,
    output ex_op_data, fwd_src, load_use, mem_bubble, stall_cycles, lu_events
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX-stage operand forwarding mux, load-use stall FSM and stall counters
module fwd_hazard_unit #(
  parameter int XLEN       = 32,
  parameter int NUM_SRC    = 2,
  parameter int REG_AW     = 5,
  parameter int HIST_DEPTH = 1
) (
  input logic              clk,
  input logic              rst,
  fwd_hazard_unit_if.slave bus
);
  typedef enum logic {RUN, LU_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [HIST_DEPTH-1:0]   hist_v_q;
  logic [REG_AW-1:0]       hist_rd_q   [HIST_DEPTH];
  logic [XLEN-1:0]         hist_data_q [HIST_DEPTH];
  logic [31:0]             stall_cycles_q;
  logic [31:0]             lu_events_q;

  logic                    hazard;
  logic [NUM_SRC*XLEN-1:0] op_data;
  logic [NUM_SRC*2-1:0]    sel;
  logic [REG_AW-1:0]       addr;
  logic                    used;
  logic                    mem_hit;
  logic                    wb_hit;

  // Sources are applied lowest priority first so later assignments win.
  always_comb begin
    hazard  = 1'b0;
    op_data = bus.ex_rs_data;
    sel     = '0;
    addr    = '0;
    used    = 1'b0;
    mem_hit = 1'b0;
    wb_hit  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      addr    = bus.ex_rs_addr[i*REG_AW +: REG_AW];
      used    = bus.ex_rs_used[i];
      mem_hit = used & bus.mem_valid & bus.mem_regwrite &
                (bus.mem_rd != '0) & (bus.mem_rd == addr);
      wb_hit  = used & bus.wb_valid & bus.wb_regwrite &
                (bus.wb_rd != '0) & (bus.wb_rd == addr);
      for (int h = HIST_DEPTH - 1; h >= 0; h--) begin
        if (used && hist_v_q[h] && (hist_rd_q[h] == addr)) begin
          sel[i*2 +: 2]            = 2'd3;
          op_data[i*XLEN +: XLEN]  = hist_data_q[h];
        end
      end
      if (wb_hit) begin
        sel[i*2 +: 2]           = 2'd2;
        op_data[i*XLEN +: XLEN] = bus.wb_data;
      end
      if (mem_hit && !bus.mem_is_load) begin
        sel[i*2 +: 2]           = 2'd1;
        op_data[i*XLEN +: XLEN] = bus.mem_data;
      end
      if (mem_hit && bus.mem_is_load && bus.ex_valid) begin
        hazard = 1'b1;
      end
    end
  end

  // A hazard seen in LU_WAIT is a younger load now in MEM; keep waiting for it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (hazard)  state_d = LU_WAIT;
      LU_WAIT: if (!hazard) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      hist_v_q       <= '0;
      stall_cycles_q <= '0;
      lu_events_q    <= '0;
      for (int h = 0; h < HIST_DEPTH; h++) begin
        hist_rd_q[h]   <= '0;
        hist_data_q[h] <= '0;
      end
    end else if (!bus.pipe_stall) begin
      state_q        <= state_d;
      hist_v_q[0]    <= bus.wb_valid & bus.wb_regwrite & (bus.wb_rd != '0);
      hist_rd_q[0]   <= bus.wb_rd;
      hist_data_q[0] <= bus.wb_data;
      for (int h = 1; h < HIST_DEPTH; h++) begin
        hist_v_q[h]    <= hist_v_q[h-1];
        hist_rd_q[h]   <= hist_rd_q[h-1];
        hist_data_q[h] <= hist_data_q[h-1];
      end
      if (hazard && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if ((state_q == RUN) && (state_d == LU_WAIT) && (lu_events_q != 32'hFFFF_FFFF)) begin
        lu_events_q <= lu_events_q + 32'd1;
      end
    end
  end

  assign bus.ex_op_data   = op_data;
  assign bus.fwd_src      = sel;
  assign bus.load_use     = hazard;
  assign bus.mem_bubble   = hazard;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.lu_events    = lu_events_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed checks of fwd_hazard_unit with 2-src/depth-1 and 3-src/depth-2 instances
module tb_fwd_hazard_unit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fwd_hazard_unit_if #(.XLEN(32), .NUM_SRC(2), .REG_AW(5)) b2 ();
  fwd_hazard_unit_if #(.XLEN(32), .NUM_SRC(3), .REG_AW(5)) b3 ();

  fwd_hazard_unit #(.XLEN(32), .NUM_SRC(2), .REG_AW(5), .HIST_DEPTH(1)) u_dut2 (
    .clk(clk), .rst(rst), .bus(b2)
  );
  fwd_hazard_unit #(.XLEN(32), .NUM_SRC(3), .REG_AW(5), .HIST_DEPTH(2)) u_dut3 (
    .clk(clk), .rst(rst), .bus(b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ev;
    logic [4:0] a0;
    logic [4:0] a1;
    logic [1:0] used;
    logic       mv;
    logic       mw;
    logic       ml;
    logic [4:0] mrd;
    logic       wv;
    logic       ww;
    logic [4:0] wrd;
    logic [1:0] s0;
    logic [1:0] s1;
    logic       lu;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] opsel(input logic [1:0] s, input logic [31:0] rf);
    case (s)
      2'd0:    opsel = rf;
      2'd1:    opsel = 32'h11;
      2'd2:    opsel = 32'h22;
      default: opsel = 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic idle2();
    b2.pipe_stall   = 1'b0;
    b2.ex_valid     = 1'b0;
    b2.ex_rs_addr   = '0;
    b2.ex_rs_used   = '0;
    b2.ex_rs_data   = '0;
    b2.mem_valid    = 1'b0;
    b2.mem_regwrite = 1'b0;
    b2.mem_is_load  = 1'b0;
    b2.mem_rd       = '0;
    b2.mem_data     = '0;
    b2.wb_valid     = 1'b0;
    b2.wb_regwrite  = 1'b0;
    b2.wb_rd        = '0;
    b2.wb_data      = '0;
  endtask

  task automatic idle3();
    b3.pipe_stall   = 1'b0;
    b3.ex_valid     = 1'b0;
    b3.ex_rs_addr   = '0;
    b3.ex_rs_used   = '0;
    b3.ex_rs_data   = '0;
    b3.mem_valid    = 1'b0;
    b3.mem_regwrite = 1'b0;
    b3.mem_is_load  = 1'b0;
    b3.mem_rd       = '0;
    b3.mem_data     = '0;
    b3.wb_valid     = 1'b0;
    b3.wb_regwrite  = 1'b0;
    b3.wb_rd        = '0;
    b3.wb_data      = '0;
  endtask

  task automatic mem_load2(input logic [4:0] rd);
    b2.mem_valid = 1'b1; b2.mem_regwrite = 1'b1; b2.mem_is_load = 1'b1;
    b2.mem_rd = rd; b2.mem_data = 32'hBAD0_BAD0;
  endtask

  task automatic wb_write2(input logic [4:0] rd, input logic [31:0] d);
    b2.wb_valid = 1'b1; b2.wb_regwrite = 1'b1; b2.wb_rd = rd; b2.wb_data = d;
  endtask

  initial begin
    logic [5:0] exp3;
    checks = 0;
    errors = 0;
    idle2();
    idle3();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Reset state
    b2.ex_valid = 1'b1; b2.ex_rs_addr = {5'd6, 5'd5}; b2.ex_rs_used = 2'b11;
    b2.ex_rs_data = {32'h9ABC_DEF0, 32'h1234_5678};
    #1;
    chk("rst_load_use", b2.load_use, 1'b0);
    chk("rst_mem_bubble", b2.mem_bubble, 1'b0);
    chk("rst_fwd_src", b2.fwd_src, 4'd0);
    chk("rst_op_data", b2.ex_op_data, 64'h9ABC_DEF0_1234_5678);
    chk("rst_stall_cycles", b2.stall_cycles, 32'd0);
    chk("rst_lu_events", b2.lu_events, 32'd0);

    //          ev    a0     a1     used   mv    mw    ml    mrd    wv    ww    wrd    s0     s1     lu
    tbl.push_back('{1'b1, 5'd5, 5'd1, 2'd3, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 2'd1, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 5'd5, 5'd1, 2'd3, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 2'd2, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 5'd2, 5'd6, 2'd3, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 5'd2, 5'd6, 2'd3, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 5'd2, 5'd6, 2'd1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 5'd0, 5'd1, 2'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 5'd0, 5'd0, 2'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 5'd0, 5'd0, 2'd3, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 5'd8, 5'd1, 2'd3, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd8, 2'd2, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 5'd3, 5'd1, 2'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 2'd2, 2'd0, 1'b1});
    tbl.push_back('{1'b1, 5'd4, 5'd4, 2'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b1});
    tbl.push_back('{1'b1, 5'd9, 5'd1, 2'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd9, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 5'd8, 5'd9, 2'd3, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 5'd8, 2'd2, 2'd1, 1'b0});
    tbl.push_back('{1'b1, 5'd5, 5'd5, 2'd3, 1'b1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 2'd1, 2'd1, 1'b0});
    tbl.push_back('{1'b1, 5'd6, 5'd6, 2'd3, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{1'b1, 5'd5, 5'd5, 2'd2, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd0, 2'd0, 2'd1, 1'b0});

    // Frozen throughout the table: outputs stay combinational, state and counters hold
    b2.pipe_stall = 1'b1;
    b2.ex_rs_data = {32'hB0, 32'hA0};
    b2.mem_data   = 32'h11;
    b2.wb_data    = 32'h22;
    for (int k = 0; k < tbl.size(); k++) begin
      b2.ex_valid     = tbl[k].ev;
      b2.ex_rs_addr   = {tbl[k].a1, tbl[k].a0};
      b2.ex_rs_used   = tbl[k].used;
      b2.mem_valid    = tbl[k].mv;
      b2.mem_regwrite = tbl[k].mw;
      b2.mem_is_load  = tbl[k].ml;
      b2.mem_rd       = tbl[k].mrd;
      b2.wb_valid     = tbl[k].wv;
      b2.wb_regwrite  = tbl[k].ww;
      b2.wb_rd        = tbl[k].wrd;
      #1;
      chk($sformatf("vec%0d_fwd_src", k), b2.fwd_src, {tbl[k].s1, tbl[k].s0});
      chk($sformatf("vec%0d_op0", k), b2.ex_op_data[31:0], opsel(tbl[k].s0, 32'hA0));
      chk($sformatf("vec%0d_op1", k), b2.ex_op_data[63:32], opsel(tbl[k].s1, 32'hB0));
      chk($sformatf("vec%0d_load_use", k), b2.load_use, tbl[k].lu);
      chk($sformatf("vec%0d_mem_bubble", k), b2.mem_bubble, tbl[k].lu);
    end
    step();
    chk("table_frozen_stall_cycles", b2.stall_cycles, 32'd0);
    chk("table_frozen_lu_events", b2.lu_events, 32'd0);

    // Load-use on rs2, then resolve from WB
    idle2();
    mem_load2(5'd6);
    b2.ex_valid = 1'b1; b2.ex_rs_addr = {5'd6, 5'd0}; b2.ex_rs_used = 2'b10;
    #1;
    chk("lu_load_use", b2.load_use, 1'b1);
    chk("lu_mem_bubble", b2.mem_bubble, 1'b1);
    step();
    b2.mem_valid = 1'b0;
    wb_write2(5'd6, 32'hDEAD);
    #1;
    chk("lu_wait_load_use", b2.load_use, 1'b0);
    chk("lu_wait_fwd_src1", b2.fwd_src[3:2], 2'd2);
    chk("lu_wait_op1", b2.ex_op_data[63:32], 32'hDEAD);
    chk("lu_wait_lu_events", b2.lu_events, 32'd1);
    chk("lu_wait_stall_cycles", b2.stall_cycles, 32'd1);
    step();

    // Load-use frozen for three cycles; HIST (x6=DEAD) must also hold
    idle2();
    mem_load2(5'd7);
    b2.ex_valid = 1'b1; b2.ex_rs_addr = {5'd6, 5'd7}; b2.ex_rs_used = 2'b11;
    b2.pipe_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("frz%0d_load_use", k), b2.load_use, 1'b1);
      chk($sformatf("frz%0d_stall_cycles", k), b2.stall_cycles, 32'd1);
      chk($sformatf("frz%0d_lu_events", k), b2.lu_events, 32'd1);
      chk($sformatf("frz%0d_hist_src1", k), b2.fwd_src[3:2], 2'd3);
      chk($sformatf("frz%0d_hist_op1", k), b2.ex_op_data[63:32], 32'hDEAD);
      step();
    end
    b2.pipe_stall = 1'b0;
    #1;
    chk("frz_release_load_use", b2.load_use, 1'b1);
    step();
    chk("frz_after_stall_cycles", b2.stall_cycles, 32'd2);
    chk("frz_after_lu_events", b2.lu_events, 32'd2);

    // Younger load raised in LU_WAIT is honoured without a new event
    idle2();
    mem_load2(5'd9);
    wb_write2(5'd7, 32'h70);
    b2.ex_valid = 1'b1; b2.ex_rs_addr = {5'd9, 5'd7}; b2.ex_rs_used = 2'b11;
    #1;
    chk("luw_new_load_use", b2.load_use, 1'b1);
    chk("luw_new_src0", b2.fwd_src[1:0], 2'd2);
    chk("luw_new_op0", b2.ex_op_data[31:0], 32'h70);
    step();
    chk("luw_new_stall_cycles", b2.stall_cycles, 32'd3);
    chk("luw_new_lu_events", b2.lu_events, 32'd2);
    idle2();
    #1;
    chk("luw_idle_load_use", b2.load_use, 1'b0);
    step();
    mem_load2(5'd6);
    b2.ex_valid = 1'b1; b2.ex_rs_addr = {5'd0, 5'd6}; b2.ex_rs_used = 2'b01;
    step();
    chk("run_again_lu_events", b2.lu_events, 32'd3);
    chk("run_again_stall_cycles", b2.stall_cycles, 32'd4);
    idle2();
    step();

    // Retired write forwarded from HIST for exactly one cycle at depth 1
    wb_write2(5'd7, 32'h55);
    step();
    idle2();
    b2.ex_valid = 1'b1; b2.ex_rs_addr = {5'd0, 5'd7}; b2.ex_rs_used = 2'b01;
    #1;
    chk("hist_src0", b2.fwd_src[1:0], 2'd3);
    chk("hist_op0", b2.ex_op_data[31:0], 32'h55);
    step();
    chk("hist_aged_src0", b2.fwd_src[1:0], 2'd0);
    chk("hist_aged_op0", b2.ex_op_data[31:0], 32'h0);

    // Reset while in LU_WAIT with a valid HIST entry
    wb_write2(5'd10, 32'h99);
    mem_load2(5'd11);
    b2.ex_valid = 1'b1; b2.ex_rs_addr = {5'd0, 5'd11}; b2.ex_rs_used = 2'b01;
    step();
    idle2();
    b2.ex_valid = 1'b1; b2.ex_rs_addr = {5'd0, 5'd10}; b2.ex_rs_used = 2'b01;
    b2.ex_rs_data = {32'h0, 32'hCAFE};
    #1;
    chk("pre_rst_hist_src0", b2.fwd_src[1:0], 2'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_stall_cycles", b2.stall_cycles, 32'd0);
    chk("post_rst_lu_events", b2.lu_events, 32'd0);
    chk("post_rst_src0", b2.fwd_src[1:0], 2'd0);
    chk("post_rst_op0", b2.ex_op_data[31:0], 32'hCAFE);
    mem_load2(5'd11);
    b2.ex_rs_addr = {5'd0, 5'd11};
    step();
    chk("post_rst_run_lu_events", b2.lu_events, 32'd1);
    chk("post_rst_run_stall_cycles", b2.stall_cycles, 32'd1);
    idle2();

    // Three-source instance: MEM over WB on each source in turn
    for (int s = 0; s < 3; s++) begin
      idle3();
      b3.ex_valid = 1'b1;
      b3.ex_rs_addr = {5'd1, 5'd1, 5'd1};
      b3.ex_rs_addr[s*5 +: 5] = 5'd5;
      b3.ex_rs_used = 3'b111;
      b3.ex_rs_data = {32'hA0, 32'hA0, 32'hA0};
      b3.mem_valid = 1'b1; b3.mem_regwrite = 1'b1; b3.mem_rd = 5'd5; b3.mem_data = 32'h11;
      b3.wb_valid = 1'b1; b3.wb_regwrite = 1'b1; b3.wb_rd = 5'd5; b3.wb_data = 32'h22;
      #1;
      exp3 = 6'd1 << (2 * s);
      chk($sformatf("n3_src%0d_mem_sel", s), b3.fwd_src, exp3);
      chk($sformatf("n3_src%0d_mem_op", s), b3.ex_op_data[s*32 +: 32], 32'h11);
      b3.mem_valid = 1'b0;
      #1;
      exp3 = 6'd2 << (2 * s);
      chk($sformatf("n3_src%0d_wb_sel", s), b3.fwd_src, exp3);
      chk($sformatf("n3_src%0d_wb_op", s), b3.ex_op_data[s*32 +: 32], 32'h22);
      step();
    end
    idle3();
    repeat (2) step();

    // Depth-2 history still forwards two cycles after the write
    b3.wb_valid = 1'b1; b3.wb_regwrite = 1'b1; b3.wb_rd = 5'd7; b3.wb_data = 32'h55;
    step();
    idle3();
    step();
    b3.ex_valid = 1'b1; b3.ex_rs_addr = {5'd7, 5'd0, 5'd0}; b3.ex_rs_used = 3'b100;
    #1;
    chk("n3_hist1_sel", b3.fwd_src, 6'b11_00_00);
    chk("n3_hist1_op", b3.ex_op_data[95:64], 32'h55);
    step();
    chk("n3_hist_gone_sel", b3.fwd_src, 6'd0);

    // Load-use on the third source only when it is used
    b3.mem_valid = 1'b1; b3.mem_regwrite = 1'b1; b3.mem_is_load = 1'b1; b3.mem_rd = 5'd12;
    b3.ex_rs_addr = {5'd12, 5'd0, 5'd0}; b3.ex_rs_used = 3'b100;
    #1;
    chk("n3_src2_load_use", b3.load_use, 1'b1);
    b3.ex_rs_used = 3'b011;
    #1;
    chk("n3_src2_unused_load_use", b3.load_use, 1'b0);
    idle3();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
